// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
//   Responder side of the SRAM-like req/addr_ok/data_ok handshake used by the
//   fetch stage. Accepts up to DEPTH outstanding word reads/writes against an
//   internal RAM and returns data_ok/rdata strictly in acceptance order, no
//   sooner than LAT cycles after the handshake.
//
//   Optional feature: define INST_RESP_DELAY_EN to build a 16-bit Galois LFSR
//   that randomly withholds addr_ok (lfsr[0]) and delays pops (lfsr[1]).
//   Without it, stall = stall_d = 0 and timing is fully deterministic.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   req        in   request valid
//   wr         in   1 = write, 0 = read
//   size       in   transfer size, ignored (always a word access)
//   wstrb      in   write byte enables
//   addr       in   byte address, word index = addr[ADDR_W+1:2]
//   wdata      in   write data
//   addr_ok    out  request accepted this cycle (combinational)
//   data_ok    out  one-cycle response pulse per accepted request
//   rdata      out  read data with data_ok, 0 for writes, else holds
//   init_we    in   back-door RAM write, bypasses the protocol
//   init_addr  in   back-door word index
//   init_data  in   back-door write data
// -----------------------------------------------------------------------------
module inst_sram_responder #(
   parameter int          ADDR_W    = 10,
   parameter int          DEPTH     = 2,
   parameter int          LAT       = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [3:0]        wstrb,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [31:0]       init_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AGE_W = $clog2(LAT + 1);

   logic [31:0]      ram    [2**ADDR_W];
   logic [31:0]      q_data [DEPTH];
   logic [AGE_W-1:0] q_age  [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;

   logic              stall, stall_d;
   logic [ADDR_W-1:0] idx;
   logic              push, pop, init_hit, head_valid;
   logic [31:0]       rd_word, push_data, head_data;
   logic [AGE_W-1:0]  head_age;

   // size and the aliased/byte-offset address bits carry no information here.
   logic unused_bits;
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

   assign idx = addr[ADDR_W+1:2];

   // Age counts clock edges since the handshake, saturating at LAT.
   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (a >= AGE_W'(LAT)) ? AGE_W'(LAT) : a + AGE_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef INST_RESP_DELAY_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign stall   = lfsr[0];
   assign stall_d = lfsr[1];
`else
   assign stall   = 1'b0;
   assign stall_d = 1'b0;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      head_valid = 1'b0;
      head_data  = '0;
      head_age   = '0;

      // A full queue refuses new requests even if it pops this same cycle.
      addr_ok   = req && (count < CNT_W'(DEPTH)) && !stall;
      push      = req && addr_ok;
      init_hit  = init_we && (init_addr == idx);
      // The back-door write lands this edge, so a same-cycle read must see it.
      rd_word   = init_hit ? init_data : ram[idx];
      push_data = wr ? 32'h0 : rd_word;

      // head_age is the age the head entry will reach at this edge. With an
      // empty queue the incoming request is the head, which lets LAT=1
      // answer in the cycle right after the handshake.
      if (count != '0) begin
         head_valid = 1'b1;
         head_data  = q_data[rd_ptr];
         head_age   = age_inc(q_age[rd_ptr]);
      end else if (push) begin
         head_valid = 1'b1;
         head_data  = push_data;
         head_age   = AGE_W'(1);
      end

      pop = head_valid && (head_age >= AGE_W'(LAT)) && !stall_d;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         data_ok <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         data_ok <= pop;
         if (pop)  rdata  <= head_data;
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage arrays are deliberately left out of reset; validity comes
   // from count/pointers, and RAM contents must survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) q_age[i] <= age_inc(q_age[i]);
      if (push) begin
         q_data[wr_ptr] <= push_data;
         q_age[wr_ptr]  <= AGE_W'(1);
      end
   end

   // The back-door write wins over a protocol write to the same word.
   always_ff @(posedge clk) begin
      if (push && wr && !init_hit) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (init_we) ram[init_addr] <= init_data;
   end

endmodule

// File: tb/tb_inst_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_responder
//   Two responders (LAT=1 and LAT=3, DEPTH=2) share one stimulus stream. Each
//   has a queue-based reference model that predicts addr_ok, data_ok and rdata
//   every cycle; directed sections pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_inst_sram_responder;

   localparam int          AW    = 10;
   localparam int          DEPTH = 2;
   localparam logic [15:0] SEED  = 16'hACE1;

   typedef struct {
      int          h;   // cycle of the handshake
      logic [31:0] d;   // response data
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req, wr, init_we;
   logic [1:0]    size;
   logic [3:0]    wstrb;
   logic [31:0]   addr, wdata, init_data;
   logic [AW-1:0] init_addr;

   int n_vec  = 0;
   int n_fail = 0;

   logic [31:0] pre [16];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;

      logic        addr_ok, data_ok;
      logic [31:0] rdata;

      inst_sram_responder #(
         .ADDR_W(AW), .DEPTH(DEPTH), .LAT(L), .LFSR_SEED(SEED)
      ) u_dut (
         .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
         .wstrb(wstrb), .addr(addr), .wdata(wdata),
         .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
         .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
      );

      // Reference model: pend holds accepted, not yet answered requests in
      // order; the head is answered at the first cycle whose ending edge
      // brings it to LAT edges since its handshake (and no pop stall).
      initial begin
         logic [31:0]   mem [2**AW];
         ent_t          pend [$];
         ent_t          e;
         bit            dok_next, exp_aok, st, sd;
         logic [31:0]   rd_next, rd_hold, rd;
         logic [AW-1:0] idx;
         int            cyc;
`ifdef INST_RESP_DELAY_EN
         logic [15:0]   lfsr_m = SEED;
`endif
         cyc      = 0;
         dok_next = 1'b0;
         rd_next  = '0;
         rd_hold  = '0;
         forever begin
            @(negedge clk);
            if (reset) begin
               pend.delete();
               dok_next = 1'b0;
               rd_hold  = '0;
`ifdef INST_RESP_DELAY_EN
               lfsr_m = SEED;
`endif
               check($sformatf("i%0d data_ok in reset", g), {31'b0, data_ok}, 32'h0);
               check($sformatf("i%0d rdata in reset", g), rdata, 32'h0);
            end else begin
               check($sformatf("i%0d data_ok", g), {31'b0, data_ok}, {31'b0, dok_next});
               if (dok_next) rd_hold = rd_next;
               check($sformatf("i%0d rdata", g), rdata, rd_hold);
`ifdef INST_RESP_DELAY_EN
               st = lfsr_m[0];
               sd = lfsr_m[1];
               lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
`else
               st = 1'b0;
               sd = 1'b0;
`endif
               exp_aok = req && (pend.size() < DEPTH) && !st;
               check($sformatf("i%0d addr_ok", g), {31'b0, addr_ok}, {31'b0, exp_aok});
               if (exp_aok) begin
                  idx = addr[AW+1:2];
                  rd  = (init_we && init_addr == idx) ? init_data : mem[idx];
                  e.h = cyc;
                  e.d = wr ? 32'h0 : rd;
                  pend.push_back(e);
                  if (wr && !(init_we && init_addr == idx))
                     for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
               end
               dok_next = 1'b0;
               if (pend.size() > 0 && cyc >= pend[0].h + L - 1 && !sd) begin
                  e        = pend.pop_front();
                  dok_next = 1'b1;
                  rd_next  = e.d;
               end
            end
            if (init_we) mem[init_addr] = init_data;
            cyc++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n_dok;
      reset     = 1'b1;
      req       = 1'b0;
      wr        = 1'b0;
      size      = 2'd2;
      wstrb     = 4'h0;
      addr      = '0;
      wdata     = '0;
      init_we   = 1'b0;
      init_addr = '0;
      init_data = '0;
      for (int i = 0; i < 16; i++) pre[i] = $urandom();
      pre[0] = 32'h02800c0c;
      pre[1] = 32'h11223344;

      repeat (3) step();
      check("reset data_ok i0", {31'b0, g_inst[0].data_ok}, 32'h0);
      check("reset rdata i1", g_inst[1].rdata, 32'h0);
      reset = 1'b0;

      // Back-door preload of the words the bench uses.
      for (int i = 0; i < 16; i++) begin
         step();
         init_we   = 1'b1;
         init_addr = AW'(i);
         init_data = pre[i];
      end
      step();
      init_we = 1'b0;

`ifndef INST_RESP_DELAY_EN
      // Single read: LAT=1 answers next cycle, LAT=3 three cycles later.
      req = 1'b1; wr = 1'b0; addr = 32'h0;
      #2 check("d1 addr_ok i0", {31'b0, g_inst[0].addr_ok}, 32'h1);
      step();
      req = 1'b0;
      #2 check("d1 data_ok i0", {31'b0, g_inst[0].data_ok}, 32'h1);
      check("d1 rdata i0", g_inst[0].rdata, 32'h02800c0c);
      check("d1 early data_ok i1", {31'b0, g_inst[1].data_ok}, 32'h0);
      step();
      step();
      #2 check("d1 data_ok i1", {31'b0, g_inst[1].data_ok}, 32'h1);
      check("d1 rdata i1", g_inst[1].rdata, 32'h02800c0c);

      // Back-to-back reads 0,4,8 with req held against LAT=3, DEPTH=2.
      step();
      req = 1'b1; addr = 32'h0;
      #2 check("d2 accept 0", {31'b0, g_inst[1].addr_ok}, 32'h1);
      step();
      addr = 32'h4;
      #2 check("d2 accept 4", {31'b0, g_inst[1].addr_ok}, 32'h1);
      step();
      addr = 32'h8;
      #2 check("d2 full stall", {31'b0, g_inst[1].addr_ok}, 32'h0);
      step();
      #2 check("d2 accept 8 with pop", {31'b0, g_inst[1].addr_ok}, 32'h1);
      check("d2 resp0 data_ok", {31'b0, g_inst[1].data_ok}, 32'h1);
      check("d2 resp0 rdata", g_inst[1].rdata, pre[0]);
      step();
      req = 1'b0;
      #2 check("d2 resp1 older entry", g_inst[1].rdata, pre[1]);
      check("d2 resp1 data_ok", {31'b0, g_inst[1].data_ok}, 32'h1);
      step();
      #2 check("d2 gap", {31'b0, g_inst[1].data_ok}, 32'h0);
      step();
      #2 check("d2 resp2 rdata", g_inst[1].rdata, pre[2]);
      check("d2 resp2 data_ok", {31'b0, g_inst[1].data_ok}, 32'h1);

      // Partial write then read back the merged word.
      repeat (3) step();
      req = 1'b1; wr = 1'b1; addr = 32'h4; wstrb = 4'b0011; wdata = 32'hAABBCCDD;
      #2 check("d3 write accept", {31'b0, g_inst[0].addr_ok}, 32'h1);
      step();
      wr = 1'b0;
      #2 check("d3 write data_ok", {31'b0, g_inst[0].data_ok}, 32'h1);
      check("d3 write rdata", g_inst[0].rdata, 32'h0);
      step();
      req = 1'b0;
      #2 check("d3 read merged", g_inst[0].rdata, 32'h1122CCDD);

      // Asynchronous reset with two requests outstanding on LAT=3.
      repeat (4) step();
      req = 1'b1; addr = 32'h0;
      step();
      addr = 32'h8;
      step();
      req = 1'b0;
      #1 reset = 1'b1;
      #1 check("d4 data_ok i0 at reset", {31'b0, g_inst[0].data_ok}, 32'h0);
      check("d4 data_ok i1 at reset", {31'b0, g_inst[1].data_ok}, 32'h0);
      check("d4 rdata i0 at reset", g_inst[0].rdata, 32'h0);
      step();
      step();
      reset = 1'b0;
      step();
      req = 1'b1; addr = 32'h4;
      step();
      req = 1'b0;
      n_dok = 0;
      for (int i = 0; i < 6; i++) begin
         #2 if (g_inst[1].data_ok) n_dok++;
         step();
      end
      check("d4 one response after reset", n_dok, 32'd1);
`endif

      // Randomized traffic over a small window so hazards and collisions
      // between protocol and back-door writes are frequent.
      for (int i = 0; i < 1500; i++) begin
         step();
         req       = ($urandom_range(9) < 6);
         wr        = ($urandom_range(99) < 35);
         size      = 2'($urandom());
         wstrb     = 4'($urandom());
         addr      = ($urandom() & ~32'h0000_0FFC) | (32'($urandom_range(7)) << 2);
         wdata     = $urandom();
         init_we   = ($urandom_range(4) == 0);
         init_addr = AW'($urandom_range(7));
         init_data = $urandom();
      end
      step();
      req     = 1'b0;
      init_we = 1'b0;
      repeat (12) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
